// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between the hpu fetch port and a host read/write port.
// One access per clock, same-cycle grants, 2-cycle read return routed back to the issuer.
module vram_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vblank,
  // hpu fetch port (read-only)
  input  logic              ppu_req,
  input  logic [15:0]       ppu_addr,
  output logic              ppu_gnt,
  output logic              ppu_rvalid,
  output logic [DATA_W-1:0] ppu_rdata,
  // host port
  input  logic              host_req,
  input  logic              host_we,
  input  logic [15:0]       host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  // RAM side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {
    OWN_PPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  typedef struct packed {
    owner_e owner;
    logic   valid;
  } pend_t;

  logic [CNT_W-1:0] wait_cnt;
  pend_t            pend;
  pend_t            pend_next;
  logic             host_starved;
  logic             host_win;

  // Only the low ADDR_W bits select a RAM word; higher bits alias.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{ppu_addr[15:ADDR_W], host_addr[15:ADDR_W]};

  // Grants are gated by reset_n so nothing reaches the RAM while reset is held.
  assign host_starved = (wait_cnt == CNT_W'(MAX_WAIT));
  assign host_win     = reset_n & host_req & (~ppu_req | vblank | host_starved);
  assign host_gnt     = host_win;
  assign ppu_gnt      = reset_n & ppu_req & ~host_win;

  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    pend_next = '{owner: OWN_PPU, valid: 1'b0};
    if (host_gnt) begin
      mem_en    = 1'b1;
      mem_we    = host_we;
      mem_addr  = host_addr[ADDR_W-1:0];
      mem_wdata = host_wdata;
      pend_next = '{owner: OWN_HOST, valid: ~host_we};
    end else if (ppu_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = ppu_addr[ADDR_W-1:0];
      pend_next = '{owner: OWN_PPU, valid: 1'b1};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (!host_req || host_gnt) begin
      wait_cnt <= '0;
    end else if (!host_starved) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Stage 1: remember who owns the read issued this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend <= '{owner: OWN_PPU, valid: 1'b0};
    end else begin
      pend <= pend_next;
    end
  end

  // Stage 2: RAM data arrives; steer it to the owner and pulse its rvalid next cycle.
  // NOTE: the rdata holding registers are reset too, so both read buses show 0 out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ppu_rvalid  <= 1'b0;
      host_rvalid <= 1'b0;
      ppu_rdata   <= '0;
      host_rdata  <= '0;
    end else begin
      ppu_rvalid  <= pend.valid && (pend.owner == OWN_PPU);
      host_rvalid <= pend.valid && (pend.owner == OWN_HOST);
      if (pend.valid && (pend.owner == OWN_PPU)) begin
        ppu_rdata <= mem_rdata;
      end
      if (pend.valid && (pend.owner == OWN_HOST)) begin
        host_rdata <= mem_rdata;
      end
    end
  end

endmodule
